// File: rtl/ins_prefetch.sv
// ins_prefetch: instruction prefetch stage of the 8051 core.
// Drives the program-fetch side of the CPU bus from a fetch counter, queues the
// returned opcode bytes in a small FIFO and hands them in order to the decoder.
// The decoder may redirect the fetch stream (jumps/calls) at any time.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_data_bus   byte from program memory, valid while o_read_en=1
//   o_addr_bus   current fetch address
//   o_read_en    fetch strobe
//   i_stall      bus claimed by a data access; suppresses fetch
//   o_ins_byte   byte at the FIFO head
//   o_ins_pc     program address of o_ins_byte
//   o_ins_valid  head byte available
//   i_ins_ready  decoder consumes the head byte when o_ins_valid=1
//   i_jmp_en     one-cycle redirect request
//   i_jmp_addr   new fetch address, sampled when i_jmp_en=1
module ins_prefetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_data_bus,
    output logic [AW-1:0] o_addr_bus,
    output logic          o_read_en,
    input  logic          i_stall,
    output logic [7:0]    o_ins_byte,
    output logic [AW-1:0] o_ins_pc,
    output logic          o_ins_valid,
    input  logic          i_ins_ready,
    input  logic          i_jmp_en,
    input  logic [AW-1:0] i_jmp_addr
);

    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] r_fetch_pc;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Fetch is gated on the current count only; a same-cycle pop does not
    // reopen a full FIFO, which costs one bubble cycle after full.
    always_comb begin
        o_read_en   = i_reset & ~i_stall & ~i_jmp_en & (r_count != FULL);
        o_ins_valid = (r_count != '0) & ~i_jmp_en;
        o_addr_bus  = r_fetch_pc;
        o_ins_byte  = r_mem[r_rd_ptr];
        // Entries are consecutive addresses ending at fetch_pc-1, so the head
        // address is recovered from the count instead of stored per entry.
        o_ins_pc    = r_fetch_pc - AW'(r_count);
        w_push      = o_read_en;
        w_pop       = o_ins_valid & i_ins_ready;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_jmp_en) begin
            // Redirect flushes the queue; push and pop are already masked off.
            r_fetch_pc <= i_jmp_addr;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data_bus;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
                r_fetch_pc      <= r_fetch_pc + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ins_prefetch.sv
// Bench for ins_prefetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_ins_prefetch;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_bus;
    logic [7:0] addr_bus;
    logic       read_en;
    logic       stall;
    logic [7:0] ins_byte;
    logic [7:0] ins_pc;
    logic       ins_valid;
    logic       ins_ready;
    logic       jmp_en;
    logic [7:0] jmp_addr;

    int n_vec = 0;
    int n_err = 0;

    ins_prefetch #(.DEPTH(DEPTH), .AW(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_data_bus  (data_bus),
        .o_addr_bus  (addr_bus),
        .o_read_en   (read_en),
        .i_stall     (stall),
        .o_ins_byte  (ins_byte),
        .o_ins_pc    (ins_pc),
        .o_ins_valid (ins_valid),
        .i_ins_ready (ins_ready),
        .i_jmp_en    (jmp_en),
        .i_jmp_addr  (jmp_addr)
    );

    // Program memory: combinational, returns addr ^ 5A.
    assign data_bus = addr_bus ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] b;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_pc = 8'h00;
    bit         m_push;
    bit         m_pop;

    function automatic bit m_read_en();
        return rst_n && !stall && !jmp_en && (q.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return rst_n && (q.size() != 0) && !jmp_en;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_pc = 8'h00;
        end else if (jmp_en) begin
            q.delete();
            m_pc = jmp_addr;
        end else begin
            m_push = m_read_en();
            m_pop  = m_valid() && ins_ready;
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back({m_pc, m_pc ^ 8'h5A});
                m_pc = m_pc + 8'h01;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_read_en", read_en, m_read_en());
        chk("m_addr_bus", addr_bus, m_pc);
        chk("m_ins_valid", ins_valid, m_valid());
        if (m_valid()) begin
            chk("m_ins_byte", ins_byte, q[0].b);
            chk("m_ins_pc", ins_pc, q[0].pc);
        end
        if (!rst_n) begin
            chk("m_rst_byte", ins_byte, 8'h00);
            chk("m_rst_pc", ins_pc, 8'h00);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] e8;

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        ins_ready = 1'b0;
        jmp_en    = 1'b0;
        jmp_addr  = 8'h00;

        // Fill from reset with the decoder idle.
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("fill_read_en", read_en, (k < 4) ? 1 : 0);
            chk("fill_addr", addr_bus, (k < 4) ? k : 4);
            chk("fill_valid", ins_valid, (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                chk("fill_byte", ins_byte, 8'h5A);
                chk("fill_pc", ins_pc, 8'h00);
            end
            step();
        end

        // Streaming with the decoder always ready.
        rst_n = 1'b0;
        step();
        ins_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("stream_read_en", read_en, 1);
            chk("stream_addr", addr_bus, k);
            chk("stream_valid", ins_valid, (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                e8 = 8'(k - 1);
                chk("stream_pc", ins_pc, e8);
                chk("stream_byte", ins_byte, e8 ^ 8'h5A);
            end
            step();
        end

        // Redirect while three bytes are queued.
        rst_n = 1'b0;
        step();
        ins_ready = 1'b0;
        rst_n     = 1'b1;
        repeat (3) step();
        jmp_en   = 1'b1;
        jmp_addr = 8'h40;
        @(negedge clk);
        chk("jmp_read_en", read_en, 0);
        chk("jmp_valid", ins_valid, 0);
        step();
        jmp_en = 1'b0;
        @(negedge clk);
        chk("jmp1_valid", ins_valid, 0);
        chk("jmp1_addr", addr_bus, 8'h40);
        chk("jmp1_read_en", read_en, 1);
        step();
        @(negedge clk);
        chk("jmp2_byte", ins_byte, 8'h1A);
        chk("jmp2_pc", ins_pc, 8'h40);
        step();
        ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e8 = 8'h40 + 8'(k);
            chk("jmp_seq_pc", ins_pc, e8);
            chk("jmp_seq_byte", ins_byte, e8 ^ 8'h5A);
            step();
        end

        // Redirect across the address wrap.
        jmp_en   = 1'b1;
        jmp_addr = 8'hFE;
        @(negedge clk);
        chk("wrap_jmp_valid", ins_valid, 0);
        step();
        jmp_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                e8 = 8'hFE + 8'(k);
                chk("wrap_addr", addr_bus, e8);
            end
            chk("wrap_valid", ins_valid, (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                e8 = 8'hFE + 8'(k - 1);
                chk("wrap_pc", ins_pc, e8);
                chk("wrap_byte", ins_byte, e8 ^ 8'h5A);
            end
            step();
        end

        // Fill, then drain under stall.
        ins_ready = 1'b0;
        repeat (6) step();
        stall     = 1'b1;
        ins_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_read_en", read_en, 0);
            chk("stall_addr", addr_bus, 8'h06);
            chk("stall_valid", ins_valid, (k < 4) ? 1 : 0);
            if (k < 4) chk("stall_pc", ins_pc, 8'h02 + 8'(k));
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_read_en", read_en, 1);
        chk("unstall_addr", addr_bus, 8'h06);
        step();

        // Asynchronous reset while full and mid-redirect.
        ins_ready = 1'b0;
        repeat (5) step();
        jmp_en   = 1'b1;
        jmp_addr = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_read_en", read_en, 0);
        chk("arst_valid", ins_valid, 0);
        chk("arst_addr", addr_bus, 8'h00);
        chk("arst_pc", ins_pc, 8'h00);
        chk("arst_byte", ins_byte, 8'h00);
        step();
        jmp_en = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("restart_read_en", read_en, 1);
        chk("restart_addr", addr_bus, 8'h00);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            ins_ready = ($urandom_range(0, 9) < 6);
            jmp_en    = ($urandom_range(0, 19) == 0);
            jmp_addr  = 8'($urandom);
            rst_n     = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
